// File: rtl/max_stream_sched_if.sv
// Handshake bundle for the max stream scheduler:
// frame control, operand input and result output.
interface max_stream_sched_if #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
);
    localparam int IDXW = $clog2(COUNT);

    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [IDXW-1:0]  out_idx;
    logic             busy;

    modport master (
        output start,
        output abort,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_max,
        input  out_idx,
        input  busy
    );

    modport slave (
        input  start,
        input  abort,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_max,
        output out_idx,
        output busy
    );
endinterface

// File: rtl/max_stream_sched.sv
// Frame max scheduler: one unsigned comparator reused
// across COUNT operands, returning max and first index.
module max_stream_sched #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
) (
    input logic               clk,
    input logic               rst_n,
    max_stream_sched_if.slave io
);
    localparam int IDXW = $clog2(COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  cnt_q, cnt_d;
    logic [IDXW-1:0]  best_idx_q, best_idx_d;
    logic [IDXW-1:0]  out_idx_q, out_idx_d;
    logic [WIDTH-1:0] best_q, best_d;
    logic [WIDTH-1:0] out_max_q, out_max_d;
    logic             take;
    logic             last;

    // First beat always seeds; later beats need a strict win
    assign take = (cnt_q == '0) || (io.in_data > best_q);
    assign last = (cnt_q == IDXW'(COUNT - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        out_max_d  = out_max_q;
        out_idx_d  = out_idx_q;
        if (io.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (io.start) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end
                end
                LOAD: begin
                    if (io.in_valid) begin
                        if (take) begin
                            best_d     = io.in_data;
                            best_idx_d = cnt_q;
                        end
                        cnt_d = cnt_q + IDXW'(1);
                        if (last) begin
                            state_d   = DONE;
                            out_max_d = best_d;
                            out_idx_d = best_idx_d;
                        end
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            out_max_q  <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            out_max_q  <= out_max_d;
            out_idx_q  <= out_idx_d;
        end
    end

    assign io.in_ready  = (state_q == LOAD);
    assign io.out_valid = (state_q == DONE);
    assign io.busy      = (state_q != IDLE);
    assign io.out_max   = out_max_q;
    assign io.out_idx   = out_idx_q;
endmodule

// File: tb/tb_max_stream_sched.sv
// Randomized bench for max_stream_sched against a
// frame-level max/first-index reference model.
module tb_max_stream_sched;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    max_stream_sched_if #(.WIDTH(8), .COUNT(4)) a_if ();
    max_stream_sched_if #(.WIDTH(2), .COUNT(2)) b_if ();

    max_stream_sched #(.WIDTH(8), .COUNT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (a_if.slave)
    );

    max_stream_sched #(.WIDTH(2), .COUNT(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (b_if.slave)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_max = '0;
    int         exp_idx = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_frame(
        input  logic [7:0] d[4],
        output logic [7:0] m,
        output int         idx
    );
        m = d[0];
        for (int i = 1; i < 4; i++)
            if (d[i] > m) m = d[i];
        idx = -1;
        for (int i = 0; i < 4; i++)
            if (idx < 0 && d[i] == m) idx = i;
    endfunction

    task automatic load_frame(input logic [7:0] d[4],
                              input int maxgap);
        a_if.start = 1'b1;
        step();
        a_if.start = 1'b0;
        chk("load_busy", 32'(a_if.busy), 1);
        chk("load_ready", 32'(a_if.in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = $urandom_range(0, maxgap);
            repeat (gap) begin
                a_if.in_valid = 1'b0;
                a_if.in_data  = 8'($urandom);
                step();
            end
            chk("stall_novalid", 32'(a_if.out_valid), 0);
            chk("stall_ready", 32'(a_if.in_ready), 1);
            a_if.in_valid = 1'b1;
            a_if.in_data  = d[i];
            step();
        end
        a_if.in_valid = 1'b0;
        ref_frame(d, exp_max, exp_idx);
        chk("done_valid", 32'(a_if.out_valid), 1);
        chk("done_max", 32'(a_if.out_max), 32'(exp_max));
        chk("done_idx", 32'(a_if.out_idx), 32'(exp_idx));
        chk("done_busy", 32'(a_if.busy), 1);
        chk("done_noready", 32'(a_if.in_ready), 0);
    endtask

    task automatic drain(input int hold, input bit st);
        a_if.out_ready = 1'b0;
        a_if.start     = st;
        repeat (hold) begin
            step();
            chk("hold_valid", 32'(a_if.out_valid), 1);
            chk("hold_max", 32'(a_if.out_max), 32'(exp_max));
            chk("hold_idx", 32'(a_if.out_idx), 32'(exp_idx));
        end
        a_if.out_ready = 1'b1;
        step();
        a_if.out_ready = 1'b0;
        a_if.start     = 1'b0;
        chk("hs_valid", 32'(a_if.out_valid), 0);
        chk("hs_busy", 32'(a_if.busy), 0);
        chk("keep_max", 32'(a_if.out_max), 32'(exp_max));
        chk("keep_idx", 32'(a_if.out_idx), 32'(exp_idx));
        step();
        chk("start_ignored", 32'(a_if.in_ready), 0);
    endtask

    task automatic rand_frame(input int maxgap);
        logic [7:0] d[4];
        for (int i = 0; i < 4; i++)
            d[i] = 8'($urandom_range(0, 7) * 32);
        load_frame(d, maxgap);
    endtask

    initial begin
        rst_n          = 1'b0;
        a_if.start     = 1'b0;
        a_if.abort     = 1'b0;
        a_if.in_valid  = 1'b0;
        a_if.in_data   = '0;
        a_if.out_ready = 1'b0;
        b_if.start     = 1'b0;
        b_if.abort     = 1'b0;
        b_if.in_valid  = 1'b0;
        b_if.in_data   = '0;
        b_if.out_ready = 1'b0;
        #12;
        chk("rst_busy", 32'(a_if.busy), 0);
        chk("rst_ready", 32'(a_if.in_ready), 0);
        chk("rst_valid", 32'(a_if.out_valid), 0);
        chk("rst_max", 32'(a_if.out_max), 0);
        chk("rst_idx", 32'(a_if.out_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // operands offered in IDLE must be ignored
        a_if.in_valid = 1'b1;
        a_if.in_data  = 8'hEE;
        step();
        step();
        a_if.in_valid = 1'b0;
        chk("idle_ready", 32'(a_if.in_ready), 0);
        chk("idle_busy", 32'(a_if.busy), 0);

        load_frame('{8'h12, 8'h7F, 8'h05, 8'h40}, 0);
        drain(5, 1'b1);
        load_frame('{8'h30, 8'h30, 8'h00, 8'h30}, 0);
        drain(0, 1'b0);
        load_frame('{8'h00, 8'h00, 8'h00, 8'h00}, 1);
        drain(1, 1'b0);
        load_frame('{8'h01, 8'h02, 8'h03, 8'hFF}, 2);
        drain(2, 1'b1);

        // abort in LOAD after two beats, with a live beat
        a_if.start = 1'b1;
        step();
        a_if.start    = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.in_data  = 8'h50;
        step();
        a_if.in_data = 8'h60;
        step();
        a_if.abort   = 1'b1;
        a_if.in_data = 8'hFF;
        step();
        a_if.abort    = 1'b0;
        a_if.in_valid = 1'b0;
        chk("abl_busy", 32'(a_if.busy), 0);
        chk("abl_valid", 32'(a_if.out_valid), 0);
        chk("abl_max", 32'(a_if.out_max), 32'(exp_max));
        step();
        chk("abl_idle", 32'(a_if.in_ready), 0);
        load_frame('{8'h01, 8'h02, 8'h03, 8'h04}, 2);
        drain(1, 1'b0);

        // abort in DONE beats handshake and start
        rand_frame(2);
        a_if.abort     = 1'b1;
        a_if.out_ready = 1'b1;
        a_if.start     = 1'b1;
        step();
        a_if.abort     = 1'b0;
        a_if.out_ready = 1'b0;
        a_if.start     = 1'b0;
        chk("abd_valid", 32'(a_if.out_valid), 0);
        chk("abd_busy", 32'(a_if.busy), 0);
        step();
        chk("abd_idle", 32'(a_if.in_ready), 0);

        // async reset between edges mid-frame
        a_if.start = 1'b1;
        step();
        a_if.start    = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.in_data  = 8'h11;
        step();
        a_if.in_data = 8'h22;
        step();
        a_if.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_max = '0;
        exp_idx = 0;
        chk("arst_busy", 32'(a_if.busy), 0);
        chk("arst_ready", 32'(a_if.in_ready), 0);
        chk("arst_valid", 32'(a_if.out_valid), 0);
        chk("arst_max", 32'(a_if.out_max), 0);
        chk("arst_idx", 32'(a_if.out_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        load_frame('{8'h09, 8'hA0, 8'hA0, 8'h03}, 1);
        drain(1, 1'b0);

        for (int f = 0; f < 20; f++) begin
            rand_frame(3);
            drain($urandom_range(0, 5), 1'($urandom));
        end

        // exhaustive COUNT=2, WIDTH=2 sweep
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                b_if.start = 1'b1;
                step();
                b_if.start    = 1'b0;
                b_if.in_valid = 1'b1;
                b_if.in_data  = 2'(a);
                step();
                b_if.in_data = 2'(b);
                step();
                b_if.in_valid = 1'b0;
                chk("sw_valid", 32'(b_if.out_valid), 1);
                chk("sw_max", 32'(b_if.out_max),
                    32'((b > a) ? b : a));
                chk("sw_idx", 32'(b_if.out_idx),
                    32'((b > a) ? 1 : 0));
                b_if.out_ready = 1'b1;
                step();
                b_if.out_ready = 1'b0;
                chk("sw_hs", 32'(b_if.out_valid), 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule
